// File: rtl/hazard_scoreboard_pkg.sv
// hazard_pkg: shared types for the hazard scoreboard (forward selects, destination classes, shadow pipe entry, INT x0 constant)
package hazard_pkg;
  localparam int MAX_AW = 8;
  localparam logic [MAX_AW-1:0] ZERO_REG = '0;
  typedef enum logic [1:0] {FWD_RF = 2'd0, FWD_MEM = 2'd1, FWD_WB = 2'd2} fwd_sel_e;
  typedef enum logic [1:0] {CLS_ALU = 2'd0, CLS_LOAD = 2'd1, CLS_MULTI = 2'd2} dst_class_e;
  typedef struct packed {
    logic valid;
    logic [MAX_AW-1:0] addr;
    logic fp;
    logic we;
    dst_class_e cls;
  } shadow_entry_t;
endpackage

// File: rtl/hazard_scoreboard_if.sv
// hazard_scoreboard_if: ID-stage bundle; master drives id_*/flush, slave returns stall, exe_fwd_sel, mc_busy
interface hazard_scoreboard_if #(parameter int NUM_SRC = 3, parameter int AW = 5, parameter int LAT_W = 4);
  logic id_valid;
  logic [NUM_SRC-1:0][AW-1:0] id_src_addr;
  logic [NUM_SRC-1:0] id_src_fp;
  logic [NUM_SRC-1:0] id_src_used;
  logic [AW-1:0] id_dst_addr;
  logic id_dst_fp;
  logic id_dst_we;
  logic [1:0] id_dst_class;
  logic [LAT_W-1:0] id_mc_lat;
  logic flush;
  logic stall;
  logic [NUM_SRC-1:0][1:0] exe_fwd_sel;
  logic mc_busy;
  modport master (
    output id_valid, id_src_addr, id_src_fp, id_src_used, id_dst_addr, id_dst_fp,
           id_dst_we, id_dst_class, id_mc_lat, flush,
    input  stall, exe_fwd_sel, mc_busy
  );
  modport slave (
    input  id_valid, id_src_addr, id_src_fp, id_src_used, id_dst_addr, id_dst_fp,
           id_dst_we, id_dst_class, id_mc_lat, flush,
    output stall, exe_fwd_sel, mc_busy
  );
endinterface

// File: rtl/hazard_scoreboard_mc_busy_tracker.sv
// mc_busy_tracker: INT/FP busy vectors + latency counter for one outstanding multi-cycle op; ports: clk, rst, set/set_addr/set_fp/lat, per-source query q_*, destination query d_*, mc_busy
module mc_busy_tracker #(
  parameter int NUM_SRC = 3,
  parameter int AW = 5,
  parameter int LAT_W = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic set,
  input  logic [AW-1:0] set_addr,
  input  logic set_fp,
  input  logic [LAT_W-1:0] lat,
  input  logic [NUM_SRC-1:0][AW-1:0] q_addr,
  input  logic [NUM_SRC-1:0] q_fp,
  output logic [NUM_SRC-1:0] q_busy,
  input  logic [AW-1:0] d_addr,
  input  logic d_fp,
  output logic d_busy,
  output logic mc_busy
);
  logic [2**AW-1:0] busy_int, busy_fp;
  logic [LAT_W-1:0] cnt;
  logic [AW-1:0] addr;
  logic fp, done;
  assign mc_busy = |cnt;
  assign done = cnt == LAT_W'(1);
  assign d_busy = d_fp ? busy_fp[d_addr] : busy_int[d_addr];
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_q
    assign q_busy[i] = q_fp[i] ? busy_fp[q_addr[i]] : busy_int[q_addr[i]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_int <= '0;
      busy_fp <= '0;
      cnt <= '0;
      addr <= '0;
      fp <= 1'b0;
    end else begin
      if (done) begin
        if (fp) busy_fp[addr] <= 1'b0;
        else busy_int[addr] <= 1'b0;
      end
      if (set) begin
        if (set_fp) busy_fp[set_addr] <= 1'b1;
        else busy_int[set_addr] <= 1'b1;
        cnt <= lat;
        addr <= set_addr;
        fp <= set_fp;
      end else if (mc_busy) begin
        cnt <= cnt - LAT_W'(1);
      end
    end
  end
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage stall/forwarding control; ports: clk, rst (async), bus (slave: id_*, flush in; stall, exe_fwd_sel, mc_busy out)
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int AW = 5,
  parameter int LAT_W = 4
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_if.slave bus
);
  // WB producers are served by the write-first regfile, so only EXE and MEM entries are kept
  shadow_entry_t exe, exe_live, mem;
  dst_class_e cls;
  logic [NUM_SRC-1:0] lu, rw, q_busy;
  logic [NUM_SRC-1:0][1:0] sel;
  logic d_busy, waw, structural, issue, mc_set;
  function automatic logic hit(shadow_entry_t e, logic [MAX_AW-1:0] a, logic f);
    return e.valid & e.we & (e.cls != CLS_MULTI) & (e.addr == a) & (e.fp == f);
  endfunction
  assign cls = bus.id_dst_class == 2'd3 ? CLS_ALU : dst_class_e'(bus.id_dst_class);
  always_comb begin
    exe_live = exe;
    exe_live.valid = exe.valid & ~bus.flush;
  end
  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    logic [MAX_AW-1:0] a;
    logic u, he, hm;
    assign a = MAX_AW'(bus.id_src_addr[s]);
    assign u = bus.id_src_used[s] & (bus.id_src_fp[s] | a != ZERO_REG);
    assign he = u & hit(exe_live, a, bus.id_src_fp[s]);
    assign hm = u & hit(mem, a, bus.id_src_fp[s]);
    assign lu[s] = he & exe.cls == CLS_LOAD;
    assign rw[s] = u & q_busy[s];
    assign sel[s] = he ? FWD_MEM : hm ? FWD_WB : FWD_RF;
  end
  assign waw = bus.id_dst_we & d_busy & (bus.id_dst_fp | MAX_AW'(bus.id_dst_addr) != ZERO_REG);
  assign structural = cls == CLS_MULTI & bus.mc_busy;
  assign bus.stall = bus.id_valid & (|lu | |rw | waw | structural);
  assign issue = bus.id_valid & ~bus.stall & ~bus.flush;
  assign mc_set = issue & cls == CLS_MULTI & bus.id_dst_we;
  mc_busy_tracker #(.NUM_SRC(NUM_SRC), .AW(AW), .LAT_W(LAT_W)) u_mc (
    .clk(clk),
    .rst(rst),
    .set(mc_set),
    .set_addr(bus.id_dst_addr),
    .set_fp(bus.id_dst_fp),
    .lat(bus.id_mc_lat),
    .q_addr(bus.id_src_addr),
    .q_fp(bus.id_src_fp),
    .q_busy(q_busy),
    .d_addr(bus.id_dst_addr),
    .d_fp(bus.id_dst_fp),
    .d_busy(d_busy),
    .mc_busy(bus.mc_busy)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exe <= '0;
      mem <= '0;
      bus.exe_fwd_sel <= '0;
    end else begin
      exe <= issue ? shadow_entry_t'{valid: 1'b1, addr: MAX_AW'(bus.id_dst_addr), fp: bus.id_dst_fp,
                                     we: bus.id_dst_we, cls: cls} : shadow_entry_t'('0);
      mem <= exe_live;
      bus.exe_fwd_sel <= issue ? sel : '0;
    end
  end
endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised hazard and forwarding controller for the integer/FP pipeline. It sits at the ID stage and tracks in-flight destination writes in an internal EXE/MEM/WB shadow pipe plus a multi-cycle (div/fdiv/fsqrt) busy scoreboard. It raises `stall` for load-use, multi-cycle RAW/WAW and structural hazards. For each source it registers forwarding selects, which the consumer uses one cycle later in EXE.

## Interface
Parameters:
- `NUM_SRC`, 3, source operands per instruction (rs1, rs2, rs3 for fused FP).
- `AW`, 5, register address width.
- `LAT_W`, 4, width of the multi-cycle latency counter.

Ports:
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  reset; asynchronous, active-high.
- `id_valid`  in  1  ID holds a valid instruction.
- `id_src_addr`  in  NUM_SRC×AW  source register addresses.
- `id_src_fp`  in  NUM_SRC  source reads the FP file (1) or the INT file (0).
- `id_src_used`  in  NUM_SRC  source is actually read.
- `id_dst_addr`  in  AW  destination address.
- `id_dst_fp`  in  1  destination is in the FP file.
- `id_dst_we`  in  1  instruction writes a register.
- `id_dst_class`  in  2  0 ALU, 1 LOAD, 2 MULTI, 3 reserved (treated as ALU).
- `id_mc_lat`  in  LAT_W  MULTI latency in cycles, 1..2^LAT_W−1.
- `flush`  in  1  squash the instruction in ID and the EXE shadow entry.
- `stall`  out  1  ID must hold; a bubble enters EXE.
- `exe_fwd_sel`  out  NUM_SRC×2  per-source select used in EXE: 0 regfile, 1 from MEM, 2 from WB.
- `mc_busy`  out  1  a multi-cycle op is outstanding.

## Operation
- Issue condition: `issue = id_valid & ~stall & ~flush`.
- Shadow pipe: three entries (EXE, MEM, WB), each holding {valid, addr, fp, we, class}.
  - Every cycle: WB←MEM, MEM←EXE.
  - EXE←ID fields on `issue`; otherwise EXE becomes invalid.
  - `flush` also invalidates the current EXE entry before it shifts.
- Match between source s and an entry requires all of: `id_src_used[s]`, entry valid, entry `we`, equal addr, and equal fp flag.
  - INT addr 0 never matches.
  - FP f0 is a real register.
- Per-source resolution, youngest first:
  - EXE match with class LOAD: stall.
  - EXE match with class ALU: select 1.
  - MEM match: select 2.
  - WB match: select 0 (the regfile is write-first).
- Multi-cycle scoreboard:
  - Two 2^AW busy vectors, one INT and one FP.
  - Issuing a MULTI instruction sets `busy[fp][dst]` and loads the counter with `id_mc_lat`.
  - The counter decrements each cycle. On the transition 1→0 the busy bit clears, and the unit writes the regfile directly that cycle.
  - MULTI entries in the shadow pipe never forward (treated as `we`=0).
- Stall sources (OR of all):
  - load-use;
  - any used source whose busy bit is set (RAW);
  - `id_dst_we` with the destination busy bit set (WAW);
  - a MULTI instruction while `mc_busy` (structural; one outstanding).
- `exe_fwd_sel` register:
  - On `issue`: the resolved selects.
  - Otherwise (bubble): all zero.
- Flush behaviour: `flush` does not clear the multi-cycle scoreboard, because an issued op always completes.
- Simultaneous events: a busy bit clearing in the same cycle as a dependent ID check is still seen as busy (registered); the dependent issues next cycle.

## Timing
- `stall`: combinational from ID inputs and registered state, same cycle. `stall` is 0 when `id_valid`=0.
- `exe_fwd_sel`: 1-cycle latency (ID→EXE).
- Load-use: exactly 1 stall cycle. The consumer then gets select 2.
- MULTI RAW with latency L issued at cycle t: the consumer stalls through cycle t+L and issues at t+L+1 with select 0.
- Reset values:
  - shadow entries invalid;
  - busy vectors 0;
  - counter 0;
  - `exe_fwd_sel`=0;
  - `mc_busy`=0;
  - `stall`=0.
- Reset asserted mid-operation: all of the above clear immediately (asynchronously); any pending multi-cycle state is lost.

## Structure
- `hazard_pkg`:
  - `fwd_sel_e` {FWD_RF=0, FWD_MEM=1, FWD_WB=2};
  - `dst_class_e` {CLS_ALU, CLS_LOAD, CLS_MULTI};
  - `shadow_entry_t` struct;
  - `ZERO_REG` constant.
- Sub-module `mc_busy_tracker`: the busy vectors, latency counter and `mc_busy`. Its interface is set/clear, address, fp flag and a query port per source plus one for the destination.

## Test plan
- ALU `x5` issued, next instruction reads `x5` as rs1 → no stall; `exe_fwd_sel[0]`=1 the cycle after the consumer's ID cycle.
- LOAD `x7`, next instruction reads `x7` as rs2 → `stall`=1 for exactly 1 cycle, then `exe_fwd_sel[1]`=2.
- FP ALU writes `f3`, next INT instruction reads `x3` → no match; select 0 and no stall. Reading `x0` after a write to `x0` also → select 0.
- fdiv `f4` with `id_mc_lat`=5:
  - an fadd reading `f4` stalls 5 cycles and issues on the 6th with select 0;
  - a second fdiv meanwhile stalls on the structural hazard.
- `flush` asserted the cycle a LOAD `x9` sits in EXE, with a reader of `x9` in ID → no stall and select 0; `mc_busy` is unaffected.
- `rst` pulsed mid-MULTI (counter=3) → `mc_busy`=0, busy bit clear, and the next reader issues with no stall.
